// File: rtl/i2c_master_ctrl_pkg.sv
// rtl/i2c_master_ctrl_pkg.sv - command codes, FSM state encodings and phase helper for the I2C master
package i2c_master_ctrl_pkg;

    // Command codes as presented by the register block
    localparam logic [1:0] I2C_CMD_START = 2'b00;
    localparam logic [1:0] I2C_CMD_WRITE = 2'b01;
    localparam logic [1:0] I2C_CMD_READ  = 2'b10;
    localparam logic [1:0] I2C_CMD_STOP  = 2'b11;

    // Sequencer states; each non-idle state is one SCL phase
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_ST_A   = 4'd1;
    localparam logic [3:0] ST_ST_B   = 4'd2;
    localparam logic [3:0] ST_ST_C   = 4'd3;
    localparam logic [3:0] ST_BIT_LO = 4'd4;
    localparam logic [3:0] ST_BIT_HI = 4'd5;
    localparam logic [3:0] ST_ACK_LO = 4'd6;
    localparam logic [3:0] ST_ACK_HI = 4'd7;
    localparam logic [3:0] ST_SP_A   = 4'd8;
    localparam logic [3:0] ST_SP_B   = 4'd9;
    localparam logic [3:0] ST_SP_C   = 4'd10;

    // Phases with SCL released: timed by clkdivhi and subject to clock stretching
    function automatic logic is_hi_phase(input logic [3:0] s);
        logic r;
        r = 1'b0;
        case (s)
            ST_ST_A, ST_ST_B, ST_BIT_HI, ST_ACK_HI, ST_SP_B, ST_SP_C: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// rtl/i2c_master_ctrl_if.sv - command/status and SCL/SDA line bundle of the I2C master sequencer
// master modport: the sequencer side (takes commands, drives line enables, reports status)
// slave modport : the register block / pad side (issues commands, returns pad values)
interface i2c_master_ctrl_if;
    logic       en;
    logic [5:0] clkdivhi;
    logic [5:0] clkdivlo;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       ack_tx;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       ack_rx;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    modport master (
        input  en, clkdivhi, clkdivlo, cmd_valid, cmd, tx_data, ack_tx, scl_in, sda_in,
        output cmd_ready, busy, done, rx_data, ack_rx, scl_oe, sda_oe
    );

    modport slave (
        output en, clkdivhi, clkdivlo, cmd_valid, cmd, tx_data, ack_tx, scl_in, sda_in,
        input  cmd_ready, busy, done, rx_data, ack_rx, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_phase_timer.sv
// rtl/i2c_phase_timer.sv - 6-bit SCL phase down-counter with load, stretch hold and expire
// Ports: clk, rst (sync, active-high), load/load_val (start a phase of load_val+1 cycles),
//        hold (freeze count while a slave stretches SCL), expire (last cycle of the phase)
module i2c_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       hold,
    output logic       expire
);
    logic [5:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 6'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (!hold && cnt != 6'd0) begin
            cnt <= cnt - 6'd1;
        end
    end

    // A stretched cycle never counts as the last one, even when the count is already 0
    assign expire = (cnt == 6'd0) && !hold;
endmodule

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - byte-level I2C master sequencer (START/WRITE/READ/STOP)
// Ports: pclk, prst (sync, active-high); bus (master modport): en, clkdivhi/clkdivlo,
//        cmd_valid/cmd/tx_data/ack_tx in, cmd_ready/busy/done/rx_data/ack_rx out,
//        scl_oe/sda_oe open-drain pull-low enables, scl_in/sda_in synchronised pad values
module i2c_master_ctrl (
    input  logic               pclk,
    input  logic               prst,
    i2c_master_ctrl_if.master  bus
);
    import i2c_master_ctrl_pkg::*;

    logic [3:0] state, next_state, start_state, ent_state;
    logic [1:0] cmd_l, ent_cmd;
    logic       ack_tx_l, ent_ack, ent_bit;
    logic [5:0] divhi_l, divlo_l, tmr_val;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic       busy_r, done_r, ack_rx_r, scl_oe_r, sda_oe_r;
    logic [7:0] rx_data_r;
    logic       accept, expire, hold, tmr_load;
    logic       scl_nx, sda_nx;

    assign accept   = bus.cmd_valid && bus.en && !busy_r;
    assign hold     = is_hi_phase(state) && !bus.scl_in;
    assign tmr_load = accept || (busy_r && expire);

    always_comb begin
        start_state = ST_IDLE;
        case (bus.cmd)
            I2C_CMD_START: start_state = ST_ST_A;
            I2C_CMD_WRITE: start_state = ST_BIT_LO;
            I2C_CMD_READ:  start_state = ST_BIT_LO;
            I2C_CMD_STOP:  start_state = ST_SP_A;
            default:       start_state = ST_IDLE;
        endcase
    end

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_ST_A:   next_state = ST_ST_B;
            ST_ST_B:   next_state = ST_ST_C;
            ST_BIT_LO: next_state = ST_BIT_HI;
            ST_BIT_HI: next_state = (bitcnt == 3'd7) ? ST_ACK_LO : ST_BIT_LO;
            ST_ACK_LO: next_state = ST_ACK_HI;
            ST_SP_A:   next_state = ST_SP_B;
            ST_SP_B:   next_state = ST_SP_C;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Values describing the phase being entered at this edge. On accept they come
    // straight from the ports because the latches are written at the same edge.
    // shreg[6] is the next data bit: shreg shifts left as BIT_HI is left.
    always_comb begin
        ent_state = accept ? start_state : next_state;
        ent_cmd   = accept ? bus.cmd : cmd_l;
        ent_ack   = accept ? bus.ack_tx : ack_tx_l;
        ent_bit   = accept ? bus.tx_data[7] : shreg[6];
        if (is_hi_phase(ent_state)) begin
            tmr_val = accept ? bus.clkdivhi : divhi_l;
        end else begin
            tmr_val = accept ? bus.clkdivlo : divlo_l;
        end
    end

    // Line drive is only changed on phase entry; IDLE keeps whatever the last
    // phase left, so SCL stays low between bytes after a START.
    always_comb begin
        scl_nx = scl_oe_r;
        sda_nx = sda_oe_r;
        case (ent_state)
            ST_ST_A:   begin scl_nx = 1'b0; sda_nx = 1'b0; end
            ST_ST_B:   begin scl_nx = 1'b0; sda_nx = 1'b1; end
            ST_ST_C:   begin scl_nx = 1'b1; sda_nx = 1'b1; end
            ST_BIT_LO: begin
                scl_nx = 1'b1;
                sda_nx = (ent_cmd == I2C_CMD_WRITE) ? !ent_bit : 1'b0;
            end
            ST_BIT_HI: scl_nx = 1'b0;
            ST_ACK_LO: begin
                scl_nx = 1'b1;
                sda_nx = (ent_cmd == I2C_CMD_READ) ? !ent_ack : 1'b0;
            end
            ST_ACK_HI: scl_nx = 1'b0;
            ST_SP_A:   begin scl_nx = 1'b1; sda_nx = 1'b1; end
            ST_SP_B:   begin scl_nx = 1'b0; sda_nx = 1'b1; end
            ST_SP_C:   begin scl_nx = 1'b0; sda_nx = 1'b0; end
            default:   ;
        endcase
    end

    i2c_phase_timer u_timer (
        .clk      (pclk),
        .rst      (prst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .hold     (hold),
        .expire   (expire)
    );

    always_ff @(posedge pclk) begin
        if (prst) begin
            state     <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rx_data_r <= 8'h00;
            ack_rx_r  <= 1'b1;
            scl_oe_r  <= 1'b0;
            sda_oe_r  <= 1'b0;
            cmd_l     <= I2C_CMD_START;
            ack_tx_l  <= 1'b1;
            divhi_l   <= 6'd0;
            divlo_l   <= 6'd0;
            bitcnt    <= 3'd0;
            shreg     <= 8'h00;
        end else begin
            done_r <= 1'b0;
            if (busy_r && !bus.en) begin
                state    <= ST_IDLE;
                busy_r   <= 1'b0;
                scl_oe_r <= 1'b0;
                sda_oe_r <= 1'b0;
            end else if (accept) begin
                state    <= ent_state;
                busy_r   <= 1'b1;
                cmd_l    <= bus.cmd;
                ack_tx_l <= bus.ack_tx;
                divhi_l  <= bus.clkdivhi;
                divlo_l  <= bus.clkdivlo;
                bitcnt   <= 3'd0;
                shreg    <= bus.tx_data;
                scl_oe_r <= scl_nx;
                sda_oe_r <= sda_nx;
            end else if (busy_r && expire) begin
                state    <= next_state;
                scl_oe_r <= scl_nx;
                sda_oe_r <= sda_nx;
                if (state == ST_BIT_HI) begin
                    shreg  <= {shreg[6:0], bus.sda_in};
                    bitcnt <= bitcnt + 3'd1;
                end
                if (state == ST_ACK_HI) begin
                    if (cmd_l == I2C_CMD_WRITE) ack_rx_r <= bus.sda_in;
                    if (cmd_l == I2C_CMD_READ)  rx_data_r <= shreg;
                end
                if (next_state == ST_IDLE) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    assign bus.cmd_ready = bus.en && !busy_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.rx_data   = rx_data_r;
    assign bus.ack_rx    = ack_rx_r;
    assign bus.scl_oe    = scl_oe_r;
    assign bus.sda_oe    = sda_oe_r;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - directed self-checking bench for i2c_master_ctrl
module tb_i2c_master_ctrl;
    logic pclk = 1'b0;
    logic prst;
    logic stretch;
    logic slave_sda;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 pclk = ~pclk;

    i2c_master_ctrl_if bus();

    // Open-drain wired-AND of master, slave data drive and slave clock stretch
    assign bus.scl_in = ~bus.scl_oe & ~stretch;
    assign bus.sda_in = ~bus.sda_oe & slave_sda;

    i2c_master_ctrl dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus)
    );

    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic a);
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.tx_data   = d;
        bus.ack_tx    = a;
        @(posedge pclk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        prst = 1'b1;
        bus.en = 1'b1; bus.cmd_valid = 1'b0; bus.cmd = 2'b00; bus.tx_data = 8'h00; bus.ack_tx = 1'b0;
        bus.clkdivhi = 6'd3; bus.clkdivlo = 6'd3;
        stretch = 1'b0; slave_sda = 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
        n_cmp++; if (bus.ack_rx !== 1'b1) begin n_err++; $display("FAIL reset_ack_rx: got %b want 1", bus.ack_rx); end
        n_cmp++; if (bus.scl_oe !== 1'b0) begin n_err++; $display("FAIL reset_scl_oe: got %b want 0", bus.scl_oe); end
        n_cmp++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_en1: got %b want 1", bus.cmd_ready); end
        bus.en = 1'b0;
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_en0: got %b want 0", bus.cmd_ready); end
        bus.en = 1'b1;
        @(negedge pclk);
        prst = 1'b0;
    endtask

    task automatic test_start();
        logic exp_done;
        issue(2'b00, 8'h00, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            @(negedge pclk);
            exp_done = (c == 13);
            n_cmp++; if (bus.done !== exp_done) begin n_err++; $display("FAIL start_done c%0d: got %b want %b", c, bus.done, exp_done); end
            if (c == 2) begin
                n_cmp++; if ({bus.busy, bus.scl_oe, bus.sda_oe} !== 3'b100) begin n_err++; $display("FAIL start_st_a: got %b want 100", {bus.busy, bus.scl_oe, bus.sda_oe}); end
            end
            if (c == 6) begin
                n_cmp++; if ({bus.scl_oe, bus.sda_oe} !== 2'b01) begin n_err++; $display("FAIL start_st_b: got %b want 01", {bus.scl_oe, bus.sda_oe}); end
            end
            if (c == 10) begin
                n_cmp++; if ({bus.scl_oe, bus.sda_oe} !== 2'b11) begin n_err++; $display("FAIL start_st_c: got %b want 11", {bus.scl_oe, bus.sda_oe}); end
            end
            if (c == 13) begin
                n_cmp++; if ({bus.busy, bus.cmd_ready, bus.scl_oe} !== 3'b011) begin n_err++; $display("FAIL start_end: got %b want 011", {bus.busy, bus.cmd_ready, bus.scl_oe}); end
            end
        end
    endtask

    task automatic test_write();
        logic       exp_done;
        logic [7:0] exp_oe;
        exp_oe = 8'h5A;
        issue(2'b01, 8'hA5, 1'b0);
        for (int c = 1; c <= 73; c++) begin
            @(negedge pclk);
            slave_sda = (c >= 65 && c <= 72) ? 1'b0 : 1'b1;
            exp_done = (c == 73);
            n_cmp++; if (bus.done !== exp_done) begin n_err++; $display("FAIL write_done c%0d: got %b want %b", c, bus.done, exp_done); end
            if (c < 65 && (c % 8) == 2) begin
                n_cmp++; if (bus.sda_oe !== exp_oe[7 - (c / 8)]) begin n_err++; $display("FAIL write_sda_bit%0d: got %b want %b", c / 8, bus.sda_oe, exp_oe[7 - (c / 8)]); end
            end
            if (c == 66) begin
                n_cmp++; if ({bus.scl_oe, bus.sda_oe} !== 2'b10) begin n_err++; $display("FAIL write_ack_lo: got %b want 10", {bus.scl_oe, bus.sda_oe}); end
            end
            if (c == 72) begin
                n_cmp++; if (bus.ack_rx !== 1'b1) begin n_err++; $display("FAIL write_ack_rx_early: got %b want 1", bus.ack_rx); end
            end
            if (c == 73) begin
                n_cmp++; if ({bus.ack_rx, bus.busy} !== 2'b00) begin n_err++; $display("FAIL write_ack_rx: got %b want 00", {bus.ack_rx, bus.busy}); end
            end
        end
        slave_sda = 1'b1;
    endtask

    task automatic test_read();
        logic       exp_done;
        logic [7:0] pat;
        pat = 8'h3C;
        issue(2'b10, 8'h00, 1'b1);
        for (int c = 1; c <= 73; c++) begin
            @(negedge pclk);
            slave_sda = (c <= 64) ? pat[7 - ((c - 1) / 8)] : 1'b1;
            exp_done = (c == 73);
            n_cmp++; if (bus.done !== exp_done) begin n_err++; $display("FAIL read_done c%0d: got %b want %b", c, bus.done, exp_done); end
            if (c == 20 || c == 66 || c == 70) begin
                n_cmp++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL read_sda_oe c%0d: got %b want 0", c, bus.sda_oe); end
            end
            if (c == 72) begin
                n_cmp++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL read_rx_early: got %h want 00", bus.rx_data); end
            end
            if (c == 73) begin
                n_cmp++; if (bus.rx_data !== 8'h3C) begin n_err++; $display("FAIL read_rx_data: got %h want 3c", bus.rx_data); end
                n_cmp++; if (bus.ack_rx !== 1'b0) begin n_err++; $display("FAIL read_ack_rx_kept: got %b want 0", bus.ack_rx); end
            end
        end
        slave_sda = 1'b1;
    endtask

    task automatic test_stretch();
        logic exp_done;
        issue(2'b01, 8'hFF, 1'b0);
        for (int c = 1; c <= 84; c++) begin
            @(negedge pclk);
            stretch = (c >= 5 && c <= 14);
            exp_done = (c == 83);
            n_cmp++; if (bus.done !== exp_done) begin n_err++; $display("FAIL stretch_done c%0d: got %b want %b", c, bus.done, exp_done); end
            if (c == 14) begin
                n_cmp++; if ({bus.busy, bus.scl_oe} !== 2'b10) begin n_err++; $display("FAIL stretch_hold: got %b want 10", {bus.busy, bus.scl_oe}); end
            end
            if (c == 83) begin
                n_cmp++; if (bus.ack_rx !== 1'b1) begin n_err++; $display("FAIL stretch_nack: got %b want 1", bus.ack_rx); end
            end
        end
        stretch = 1'b0;
    endtask

    task automatic test_abort();
        issue(2'b01, 8'hA5, 1'b0);
        slave_sda = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge pclk);
            if (c == 30) bus.en = 1'b0;
            n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL abort_done c%0d: got %b want 0", c, bus.done); end
            if (c == 30) begin
                n_cmp++; if ({bus.busy, bus.scl_oe, bus.sda_oe} !== 3'b101) begin n_err++; $display("FAIL abort_pre: got %b want 101", {bus.busy, bus.scl_oe, bus.sda_oe}); end
            end
            if (c == 31 || c == 34) begin
                n_cmp++; if ({bus.busy, bus.scl_oe, bus.sda_oe, bus.cmd_ready} !== 4'b0000) begin n_err++; $display("FAIL abort_idle c%0d: got %b want 0000", c, {bus.busy, bus.scl_oe, bus.sda_oe, bus.cmd_ready}); end
            end
            if (c == 100) begin
                n_cmp++; if ({bus.ack_rx, bus.rx_data} !== {1'b1, 8'h3C}) begin n_err++; $display("FAIL abort_kept: got %b/%h want 1/3c", bus.ack_rx, bus.rx_data); end
            end
        end
        slave_sda = 1'b1;
        bus.en = 1'b1;
        #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL abort_reenable: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_stop();
        logic exp_done;
        bus.clkdivlo = 6'd0;
        bus.clkdivhi = 6'd63;
        issue(2'b11, 8'h00, 1'b0);
        for (int c = 1; c <= 131; c++) begin
            @(negedge pclk);
            exp_done = (c == 130);
            n_cmp++; if (bus.done !== exp_done) begin n_err++; $display("FAIL stop_done c%0d: got %b want %b", c, bus.done, exp_done); end
            if (c == 1) begin
                n_cmp++; if ({bus.busy, bus.scl_oe, bus.sda_oe} !== 3'b111) begin n_err++; $display("FAIL stop_sp_a: got %b want 111", {bus.busy, bus.scl_oe, bus.sda_oe}); end
            end
            if (c == 2 || c == 65) begin
                n_cmp++; if ({bus.scl_oe, bus.sda_oe} !== 2'b01) begin n_err++; $display("FAIL stop_sp_b c%0d: got %b want 01", c, {bus.scl_oe, bus.sda_oe}); end
            end
            if (c == 66 || c == 129) begin
                n_cmp++; if ({bus.busy, bus.scl_oe, bus.sda_oe} !== 3'b100) begin n_err++; $display("FAIL stop_sp_c c%0d: got %b want 100", c, {bus.busy, bus.scl_oe, bus.sda_oe}); end
            end
            if (c == 130) begin
                n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL stop_busy_end: got %b want 0", bus.busy); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        bus.clkdivlo = 6'd0;
        bus.clkdivhi = 6'd0;
        issue(2'b00, 8'h00, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge pclk);
            if (c == 2) begin bus.cmd_valid = 1'b1; bus.cmd = 2'b11; end
            if (c == 5) bus.cmd_valid = 1'b0;
            exp_done = (c == 4 || c == 8);
            n_cmp++; if (bus.done !== exp_done) begin n_err++; $display("FAIL b2b_done c%0d: got %b want %b", c, bus.done, exp_done); end
            if (c == 2) begin
                n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_not_ready: got %b want 0", bus.cmd_ready); end
            end
            if (c == 3) begin
                n_cmp++; if ({bus.busy, bus.scl_oe, bus.sda_oe} !== 3'b111) begin n_err++; $display("FAIL b2b_st_c: got %b want 111", {bus.busy, bus.scl_oe, bus.sda_oe}); end
            end
            if (c == 4) begin
                n_cmp++; if ({bus.busy, bus.cmd_ready} !== 2'b01) begin n_err++; $display("FAIL b2b_ready: got %b want 01", {bus.busy, bus.cmd_ready}); end
            end
            if (c == 6) begin
                n_cmp++; if ({bus.busy, bus.scl_oe, bus.sda_oe} !== 3'b101) begin n_err++; $display("FAIL b2b_sp_b: got %b want 101", {bus.busy, bus.scl_oe, bus.sda_oe}); end
            end
            if (c == 7) begin
                n_cmp++; if ({bus.scl_oe, bus.sda_oe} !== 2'b00) begin n_err++; $display("FAIL b2b_sp_c: got %b want 00", {bus.scl_oe, bus.sda_oe}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_write();
        test_read();
        test_stretch();
        test_abort();
        test_stop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
